// File: rtl/axi_resp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : axi_resp_pkg                                               |
// | Brief   : Shared response codes, snoop opcode and FSM state types    |
// |           for the AXI memory responder.                              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package axi_resp_pkg;

    localparam logic [1:0] AXI_RESP_OKAY        = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR      = 2'b10;
    localparam logic [3:0] AC_SNOOP_MAKEINVALID = 4'hD;
    localparam logic [2:0] AXI_SIZE_8_BYTES     = 3'd3;

    typedef enum logic [0:0] {
        R_IDLE  = 1'b0,
        R_BURST = 1'b1
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_DATA  = 2'd1,
        W_SNOOP = 2'd2,
        W_RESP  = 2'd3
    } wr_state_t;

endpackage : axi_resp_pkg
`default_nettype wire

// File: rtl/axi_mem_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : axi_mem_array                                              |
// | Brief   : Word memory with one asynchronous read port and one        |
// |           byte-enabled synchronous write port. Contents survive reset|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module axi_mem_array #(
    parameter  int DATA_WIDTH = 64,
    parameter  int MEM_WORDS  = 4096,
    localparam int IDX_W      = $clog2(MEM_WORDS),
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic [IDX_W-1:0]      i_rd_idx,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    input  logic                  i_wr_en,
    input  logic [IDX_W-1:0]      i_wr_idx,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [STRB_WIDTH-1:0] i_wr_strb
);

    logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

    // Read is combinational, so a same-cycle write shows up only after the edge.
    assign o_rd_data = r_mem[i_rd_idx];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (i_wr_strb[b]) begin
                    r_mem[i_wr_idx][b*8 +: 8] <= i_wr_data[b*8 +: 8];
                end
            end
        end
    end

endmodule : axi_mem_array
`default_nettype wire

// File: rtl/axi_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : axi_mem_responder                                          |
// | Brief   : AXI4 memory slave with independent read/write burst FSMs;  |
// |           each write burst is followed by a MakeInvalid snoop.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module axi_mem_responder
    import axi_resp_pkg::*;
#(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int MEM_WORDS  = 4096,
    parameter int LINE_BYTES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    // write address
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awlock,
    input  logic [3:0]            s_axi_awcache,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    // write data
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    // write response
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    // read address
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arlock,
    input  logic [3:0]            s_axi_arcache,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    // read data
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    // snoop address
    output logic                  s_axi_acvalid,
    input  logic                  s_axi_acready,
    output logic [ADDR_WIDTH-1:0] s_axi_acaddr,
    output logic [3:0]            s_axi_acsnoop
);

    localparam int                    IDX_W       = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] c_line_mask = ~(ADDR_WIDTH'(LINE_BYTES - 1));
    localparam logic [IDX_W-1:0]      c_idx_one   = IDX_W'(1);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic w_ar_err;
    logic w_aw_err;

    assign w_ar_err = (|s_axi_araddr[ADDR_WIDTH-1:IDX_W+3]) || (s_axi_arsize != AXI_SIZE_8_BYTES);
    assign w_aw_err = (|s_axi_awaddr[ADDR_WIDTH-1:IDX_W+3]) || (s_axi_awsize != AXI_SIZE_8_BYTES);

    // Burst type is ignored (everything is INCR), as are the protection hints.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, s_axi_awburst, s_axi_arburst, s_axi_awlock, s_axi_arlock,
                           s_axi_awcache, s_axi_arcache, s_axi_awprot, s_axi_arprot,
                           s_axi_awaddr[2:0], s_axi_araddr[2:0]};

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    rd_state_t           r_rd_state;
    logic                r_arready;
    logic                r_rvalid;
    logic [ID_WIDTH-1:0] r_rd_id;
    logic [IDX_W-1:0]    r_rd_idx;
    logic [7:0]          r_rd_len;
    logic [7:0]          r_rd_beat;
    logic                r_rd_err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_state <= R_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rd_id    <= '0;
            r_rd_idx   <= '0;
            r_rd_len   <= '0;
            r_rd_beat  <= '0;
            r_rd_err   <= 1'b0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (r_arready && s_axi_arvalid) begin
                        r_rd_id    <= s_axi_arid;
                        r_rd_idx   <= s_axi_araddr[IDX_W+2:3];
                        r_rd_len   <= s_axi_arlen;
                        r_rd_beat  <= '0;
                        r_rd_err   <= w_ar_err;
                        r_arready  <= 1'b0;
                        r_rvalid   <= 1'b1;
                        r_rd_state <= R_BURST;
                    end
                end
                R_BURST: begin
                    if (s_axi_rready) begin
                        if (r_rd_beat == r_rd_len) begin
                            r_rvalid   <= 1'b0;
                            r_arready  <= 1'b1;
                            r_rd_state <= R_IDLE;
                        end else begin
                            r_rd_beat <= r_rd_beat + 8'd1;
                            r_rd_idx  <= r_rd_idx + c_idx_one;
                            // Walking off the top word poisons the rest of the burst.
                            if (&r_rd_idx) begin
                                r_rd_err <= 1'b1;
                            end
                        end
                    end
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    wr_state_t             r_wr_state;
    logic                  r_awready;
    logic                  r_wready;
    logic                  r_acvalid;
    logic                  r_bvalid;
    logic [ID_WIDTH-1:0]   r_wr_id;
    logic [ADDR_WIDTH-1:0] r_wr_line;
    logic [IDX_W-1:0]      r_wr_idx;
    logic [7:0]            r_wr_len;
    logic [7:0]            r_wr_beat;
    logic                  r_wr_err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_state <= W_IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_acvalid  <= 1'b0;
            r_bvalid   <= 1'b0;
            r_wr_id    <= '0;
            r_wr_line  <= '0;
            r_wr_idx   <= '0;
            r_wr_len   <= '0;
            r_wr_beat  <= '0;
            r_wr_err   <= 1'b0;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    r_awready <= 1'b1;
                    if (r_awready && s_axi_awvalid) begin
                        r_wr_id    <= s_axi_awid;
                        r_wr_line  <= s_axi_awaddr & c_line_mask;
                        r_wr_idx   <= s_axi_awaddr[IDX_W+2:3];
                        r_wr_len   <= s_axi_awlen;
                        r_wr_beat  <= '0;
                        r_wr_err   <= w_aw_err;
                        r_awready  <= 1'b0;
                        r_wready   <= 1'b1;
                        r_wr_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (s_axi_wvalid) begin
                        // The burst length comes from awlen; a misplaced wlast only flags an error.
                        if (s_axi_wlast != (r_wr_beat == r_wr_len)) begin
                            r_wr_err <= 1'b1;
                        end
                        if (r_wr_beat == r_wr_len) begin
                            r_wready   <= 1'b0;
                            r_acvalid  <= 1'b1;
                            r_wr_state <= W_SNOOP;
                        end else begin
                            r_wr_beat <= r_wr_beat + 8'd1;
                            r_wr_idx  <= r_wr_idx + c_idx_one;
                            if (&r_wr_idx) begin
                                r_wr_err <= 1'b1;
                            end
                        end
                    end
                end
                W_SNOOP: begin
                    if (s_axi_acready) begin
                        r_acvalid  <= 1'b0;
                        r_bvalid   <= 1'b1;
                        r_wr_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        r_bvalid   <= 1'b0;
                        r_awready  <= 1'b1;
                        r_wr_state <= W_IDLE;
                    end
                end
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic                  w_mem_wr_en;
    logic [DATA_WIDTH-1:0] w_mem_rd_data;

    assign w_mem_wr_en = r_wready && s_axi_wvalid && !r_wr_err;

    axi_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_WORDS  (MEM_WORDS)
    ) u_mem (
        .clk       (clk),
        .i_rd_idx  (r_rd_idx),
        .o_rd_data (w_mem_rd_data),
        .i_wr_en   (w_mem_wr_en),
        .i_wr_idx  (r_wr_idx),
        .i_wr_data (s_axi_wdata),
        .i_wr_strb (s_axi_wstrb)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rid     = r_rd_id;
    assign s_axi_rdata   = r_rd_err ? '0 : w_mem_rd_data;
    assign s_axi_rresp   = r_rd_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    assign s_axi_rlast   = (r_rd_beat == r_rd_len);

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_acvalid = r_acvalid;
    assign s_axi_acaddr  = r_wr_line;
    assign s_axi_acsnoop = AC_SNOOP_MAKEINVALID;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bid     = r_wr_id;
    assign s_axi_bresp   = r_wr_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

endmodule : axi_mem_responder
`default_nettype wire

// File: tb/tb_axi_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_axi_mem_responder                                       |
// | Brief   : Directed self-checking bench for axi_mem_responder.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_axi_mem_responder;

    localparam int LIMIT = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [12:0] s_axi_awid = '0;
    logic [63:0] s_axi_awaddr = '0;
    logic [7:0]  s_axi_awlen = '0;
    logic [2:0]  s_axi_awsize = 3'd3;
    logic [1:0]  s_axi_awburst = 2'b01;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [63:0] s_axi_wdata = '0;
    logic [7:0]  s_axi_wstrb = '0;
    logic        s_axi_wlast = 1'b0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [12:0] s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [12:0] s_axi_arid = '0;
    logic [63:0] s_axi_araddr = '0;
    logic [7:0]  s_axi_arlen = '0;
    logic [2:0]  s_axi_arsize = 3'd3;
    logic [1:0]  s_axi_arburst = 2'b01;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [12:0] s_axi_rid;
    logic [63:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;
    logic        s_axi_acvalid;
    logic        s_axi_acready = 1'b0;
    logic [63:0] s_axi_acaddr;
    logic [3:0]  s_axi_acsnoop;

    int checks = 0;
    int failures = 0;

    logic [63:0] wd    [8];
    logic [63:0] exp_d [8];
    logic [1:0]  exp_r [8];

    always #5 clk = ~clk;

    axi_mem_responder dut (
        .clk           (clk),
        .reset         (reset),
        .s_axi_awid    (s_axi_awid),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_awsize  (s_axi_awsize),
        .s_axi_awburst (s_axi_awburst),
        .s_axi_awlock  (1'b0),
        .s_axi_awcache (4'h0),
        .s_axi_awprot  (3'h0),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bid     (s_axi_bid),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_arid    (s_axi_arid),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arsize  (s_axi_arsize),
        .s_axi_arburst (s_axi_arburst),
        .s_axi_arlock  (1'b0),
        .s_axi_arcache (4'h0),
        .s_axi_arprot  (3'h0),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rid     (s_axi_rid),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .s_axi_acvalid (s_axi_acvalid),
        .s_axi_acready (s_axi_acready),
        .s_axi_acaddr  (s_axi_acaddr),
        .s_axi_acsnoop (s_axi_acsnoop)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int n);
        checks++;
        assert (n < LIMIT) else begin
            failures++;
            $error("FAIL %s waited=%0d cycles limit=%0d", tag, n, LIMIT);
        end
    endtask

    task automatic ar_send(input logic [63:0] addr, input logic [7:0] len, input logic [12:0] id);
        int n;
        s_axi_araddr  = addr;
        s_axi_arlen   = len;
        s_axi_arid    = id;
        s_axi_arvalid = 1'b1;
        n = 0;
        while (s_axi_arready !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        wait_done("ar_wait", n);
        @(negedge clk);
        s_axi_arvalid = 1'b0;
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [7:0] len, input logic [12:0] id,
                           input bit toggle, input string tag);
        int beat, cyc, n;
        ar_send(addr, len, id);
        beat = 0;
        cyc  = 0;
        n    = 0;
        while (beat <= int'(len) && n < LIMIT) begin
            s_axi_rready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (s_axi_rvalid === 1'b1) begin
                check({tag, "_rdata"}, s_axi_rdata, exp_d[beat]);
                check({tag, "_rresp"}, 64'(s_axi_rresp), 64'(exp_r[beat]));
                if (s_axi_rready) begin
                    check({tag, "_rid"}, 64'(s_axi_rid), 64'(id));
                    check({tag, "_rlast"}, 64'(s_axi_rlast), 64'(beat == int'(len)));
                    beat++;
                end
            end
            @(negedge clk);
            n++;
            cyc++;
        end
        s_axi_rready = 1'b0;
        wait_done({tag, "_beats"}, n);
        check({tag, "_rvalid_after"}, 64'(s_axi_rvalid), 64'd0);
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [7:0] len, input logic [12:0] id,
                            input logic [7:0] strb, input int wlast_at, input logic [1:0] exp_bresp,
                            input logic [63:0] exp_ac, input string tag);
        int n;
        s_axi_awaddr  = addr;
        s_axi_awlen   = len;
        s_axi_awid    = id;
        s_axi_awvalid = 1'b1;
        n = 0;
        while (s_axi_awready !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        wait_done({tag, "_aw_wait"}, n);
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            s_axi_wdata  = wd[b];
            s_axi_wstrb  = strb;
            s_axi_wlast  = (b == wlast_at);
            s_axi_wvalid = 1'b1;
            n = 0;
            while (s_axi_wready !== 1'b1 && n < LIMIT) begin
                @(negedge clk);
                n++;
            end
            wait_done({tag, "_w_wait"}, n);
            @(negedge clk);
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        n = 0;
        while (s_axi_acvalid !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        wait_done({tag, "_ac_wait"}, n);
        check({tag, "_acaddr"}, s_axi_acaddr, exp_ac);
        check({tag, "_acsnoop"}, 64'(s_axi_acsnoop), 64'hD);
        check({tag, "_bvalid_before_snoop"}, 64'(s_axi_bvalid), 64'd0);
        s_axi_acready = 1'b1;
        @(negedge clk);
        s_axi_acready = 1'b0;
        check({tag, "_acvalid_once"}, 64'(s_axi_acvalid), 64'd0);
        n = 0;
        while (s_axi_bvalid !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        wait_done({tag, "_b_wait"}, n);
        check({tag, "_bresp"}, 64'(s_axi_bresp), 64'(exp_bresp));
        check({tag, "_bid"}, 64'(s_axi_bid), 64'(id));
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
        check({tag, "_bvalid_after"}, 64'(s_axi_bvalid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset held: every handshake output low.
        repeat (3) @(negedge clk);
        check("rst_arready", 64'(s_axi_arready), 64'd0);
        check("rst_awready", 64'(s_axi_awready), 64'd0);
        check("rst_wready",  64'(s_axi_wready),  64'd0);
        check("rst_rvalid",  64'(s_axi_rvalid),  64'd0);
        check("rst_bvalid",  64'(s_axi_bvalid),  64'd0);
        check("rst_acvalid", 64'(s_axi_acvalid), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_arready", 64'(s_axi_arready), 64'd1);
        check("idle_awready", 64'(s_axi_awready), 64'd1);

        // Four-beat burst at 0x40, then read it back.
        wd[0] = 64'h11; wd[1] = 64'h22; wd[2] = 64'h33; wd[3] = 64'h44;
        do_write(64'h40, 8'd3, 13'h123, 8'hFF, 3, 2'b00, 64'h40, "wr40");
        exp_d[0] = 64'h11; exp_d[1] = 64'h22; exp_d[2] = 64'h33; exp_d[3] = 64'h44;
        for (int i = 0; i < 8; i++) exp_r[i] = 2'b00;
        do_read(64'h40, 8'd3, 13'h055, 1'b0, "rd40");

        // Byte strobes: only the low four bytes are overwritten.
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        do_write(64'h0, 8'd0, 13'h001, 8'hFF, 0, 2'b00, 64'h0, "wr0_full");
        wd[0] = 64'h0;
        do_write(64'h0, 8'd0, 13'h002, 8'h0F, 0, 2'b00, 64'h0, "wr0_low");
        exp_d[0] = 64'hFFFF_FFFF_0000_0000;
        do_read(64'h0, 8'd0, 13'h003, 1'b0, "rd0");

        // Out-of-range address: index bits alias word 0, which must not change.
        exp_d[0] = 64'h0;
        exp_r[0] = 2'b10;
        do_read(64'h8000, 8'd0, 13'h004, 1'b0, "rd_oor");
        wd[0] = 64'h1234;
        do_write(64'h8000, 8'd0, 13'h005, 8'hFF, 0, 2'b10, 64'h8000, "wr_oor");
        exp_d[0] = 64'hFFFF_FFFF_0000_0000;
        exp_r[0] = 2'b00;
        do_read(64'h0, 8'd0, 13'h006, 1'b0, "rd0_again");

        // Burst running off the last word errors on the second beat.
        wd[0] = 64'hCAFE;
        do_write(64'h7FF8, 8'd0, 13'h007, 8'hFF, 0, 2'b00, 64'h7FC0, "wr_top");
        exp_d[0] = 64'hCAFE; exp_r[0] = 2'b00;
        exp_d[1] = 64'h0;    exp_r[1] = 2'b10;
        do_read(64'h7FF8, 8'd1, 13'h008, 1'b0, "rd_top");

        // Eight-beat burst read back with rready toggling.
        for (int i = 0; i < 8; i++) begin
            wd[i]    = 64'h0123_4567_89AB_CD00 + 64'(i);
            exp_d[i] = 64'h0123_4567_89AB_CD00 + 64'(i);
            exp_r[i] = 2'b00;
        end
        do_write(64'h100, 8'd7, 13'h009, 8'hFF, 7, 2'b00, 64'h100, "wr100");
        do_read(64'h100, 8'd7, 13'h00A, 1'b1, "rd100_stall");

        // Early wlast: burst still runs four beats, then SLVERR.
        wd[0] = 64'hA; wd[1] = 64'hB; wd[2] = 64'hC; wd[3] = 64'hD;
        do_write(64'h200, 8'd3, 13'h00B, 8'hFF, 1, 2'b10, 64'h200, "wr_wlast");

        // Reset in the middle of a read burst.
        ar_send(64'h100, 8'd7, 13'h00C);
        n = 0;
        while (s_axi_rvalid !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        wait_done("rst_mid_rvalid_wait", n);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_rvalid",  64'(s_axi_rvalid),  64'd0);
        check("rst_mid_arready", 64'(s_axi_arready), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_rel_arready", 64'(s_axi_arready), 64'd1);
        exp_d[0] = 64'h0123_4567_89AB_CD00;
        exp_r[0] = 2'b00;
        do_read(64'h100, 8'd0, 13'h00D, 1'b0, "rd_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_axi_mem_responder
`default_nettype wire
